// File: rtl/router_pkg.sv
// Shared definitions for the router receive path: header field layout,
// receive FSM states and the running-parity helper.
package router_pkg;

    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;
    localparam int HDR_ADDR_W  = 2;
    localparam int HDR_LEN_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    // Wide enough for len+1 outstanding reads/bytes (max 64).
    localparam int LEFT_W = HDR_LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        BODY     = 2'd2,
        DONE     = 2'd3
    } rx_state_e;

    function automatic logic [7:0] rx_parity(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_port_rx_if.sv
// FIFO-side handshake and per-packet status bundle of one router output port.
// master = receive engine, slave = FIFO / downstream environment.
interface router_port_rx_if
    import router_pkg::*;
#(
    parameter int CNT_W = 16
);

    logic                  fifo_valid;
    logic [7:0]            fifo_data;
    logic                  hold;
    logic                  rd_en;

    logic [7:0]            byte_out;
    logic                  byte_valid;
    logic [HDR_LEN_W-1:0]  pkt_len;
    logic [HDR_ADDR_W-1:0] pkt_addr;
    logic                  pkt_done;
    logic                  parity_err;
    logic                  addr_err;
    logic                  abort;
    logic [CNT_W-1:0]      pkt_count;
    logic [CNT_W-1:0]      err_count;

    modport master (
        input  fifo_valid, fifo_data, hold,
        output rd_en, byte_out, byte_valid, pkt_len, pkt_addr,
               pkt_done, parity_err, addr_err, abort, pkt_count, err_count
    );

    modport slave (
        output fifo_valid, fifo_data, hold,
        input  rd_en, byte_out, byte_valid, pkt_len, pkt_addr,
               pkt_done, parity_err, addr_err, abort, pkt_count, err_count
    );

endinterface

// File: rtl/router_rx_watchdog.sv
// Mid-packet idle timer: counts enabled cycles without a consumed byte and
// flags expiry on the TIMEOUT-th consecutive one.
module router_rx_watchdog #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    assign expired = en && !clr && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || !en || expired) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/router_port_rx.sv
// Receive engine for one router output port: drains the port FIFO, re-frames
// {len,addr} header / payload / parity packets and reports status and counters.
module router_port_rx
    import router_pkg::*;
#(
    parameter logic [HDR_ADDR_W-1:0] PORT_ID = 2'd0,
    parameter int                    TIMEOUT = 32,
    parameter int                    CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    router_port_rx_if.master bus
);

    rx_state_e state, state_nxt;

    logic                  rd_en;
    logic                  rd_q;
    logic [LEFT_W-1:0]     req_left, req_nxt, req_eff;
    logic [LEFT_W-1:0]     rcv_left;
    logic [7:0]            par_acc;
    logic [HDR_LEN_W-1:0]  len_q;
    logic [HDR_ADDR_W-1:0] addr_q;
    logic                  perr_q, aerr_q, abort_q;
    logic [CNT_W-1:0]      pkt_cnt, err_cnt;

    logic [HDR_LEN_W-1:0]  hdr_len;
    logic [HDR_ADDR_W-1:0] hdr_addr;
    logic                  hdr_cap, body_byte, par_byte, pay_byte;
    logic                  wd_en, expired;

    assign hdr_len  = bus.fifo_data[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_addr = bus.fifo_data[HDR_ADDR_W-1:0];

    // The next header may already be in flight when the FSM sits in IDLE,
    // because the read is issued from the DONE status cycle.
    assign hdr_cap   = rd_q && ((state == IDLE) || (state == HDR_WAIT));
    assign body_byte = rd_q && (state == BODY);
    assign par_byte  = body_byte && (rcv_left == LEFT_W'(1));
    assign pay_byte  = body_byte && (rcv_left != LEFT_W'(1));

    // Header length feeds the read budget in its own arrival cycle so the
    // first payload read follows the header read back-to-back.
    assign req_eff = hdr_cap ? ({1'b0, hdr_len} + LEFT_W'(1)) : req_left;
    assign rd_en   = bus.fifo_valid && !bus.hold && (req_eff != '0);

    assign wd_en = (state == HDR_WAIT) || (state == BODY);

    router_rx_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .en      (wd_en),
        .clr     (rd_q),
        .expired (expired)
    );

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        req_nxt   = req_left - {{(LEFT_W-1){1'b0}}, rd_en};

        unique case (state)
            IDLE: begin
                if (hdr_cap)    state_nxt = BODY;
                else if (rd_en) state_nxt = HDR_WAIT;
            end
            HDR_WAIT: begin
                if (hdr_cap) state_nxt = BODY;
            end
            BODY: begin
                if (par_byte) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Rearming as the parity byte lands lets the next header read overlap DONE.
        if (hdr_cap) begin
            req_nxt = req_eff - {{(LEFT_W-1){1'b0}}, rd_en};
        end else if (par_byte) begin
            req_nxt = LEFT_W'(1);
        end

        if (expired) begin
            state_nxt = IDLE;
            req_nxt   = rd_en ? '0 : LEFT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_left <= LEFT_W'(1);
            rd_q     <= 1'b0;
            rcv_left <= '0;
            par_acc  <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            perr_q   <= 1'b0;
            aerr_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_left <= req_nxt;
            rd_q     <= rd_en;
            abort_q  <= expired;

            if (hdr_cap) begin
                len_q    <= hdr_len;
                addr_q   <= hdr_addr;
                par_acc  <= bus.fifo_data;
                rcv_left <= {1'b0, hdr_len} + LEFT_W'(1);
            end else if (body_byte) begin
                rcv_left <= rcv_left - LEFT_W'(1);
                if (pay_byte) par_acc <= rx_parity(par_acc, bus.fifo_data);
            end

            if (par_byte) begin
                perr_q <= (bus.fifo_data != par_acc);
                aerr_q <= (addr_q != PORT_ID);
            end
        end
    end

    // Counters saturate; an aborted packet counts as an error but not as completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if ((state == DONE) && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if ((((state == DONE) && (perr_q || aerr_q)) || expired) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign bus.rd_en      = rd_en;
    assign bus.byte_valid = pay_byte;
    assign bus.byte_out   = pay_byte ? bus.fifo_data : 8'h00;
    assign bus.pkt_len    = len_q;
    assign bus.pkt_addr   = addr_q;
    assign bus.pkt_done   = (state == DONE);
    assign bus.parity_err = (state == DONE) && perr_q;
    assign bus.addr_err   = (state == DONE) && aerr_q;
    assign bus.abort      = abort_q;
    assign bus.pkt_count  = pkt_cnt;
    assign bus.err_count  = err_cnt;

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: behavioural port FIFO, table of packets with
// hand-computed status, plus timeout, hold and mid-packet reset sequences.
module tb_router_port_rx;
    import router_pkg::*;

    localparam logic [1:0] PORT_ID = 2'd2;
    localparam int         TIMEOUT = 32;
    localparam int         CNT_W   = 16;

    logic clk;
    logic rst;

    router_port_rx_if #(.CNT_W(CNT_W)) bus ();

    router_port_rx #(
        .PORT_ID (PORT_ID),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port FIFO model: data appears the cycle after rd_en is sampled.
    logic [7:0] fifo_q [$];
    int         push_cnt = 0;
    int         pop_cnt  = 0;
    logic [7:0] fifo_rdata = 8'h00;

    assign bus.fifo_valid = (push_cnt != pop_cnt);
    assign bus.fifo_data  = fifo_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q.delete();
            pop_cnt    <= push_cnt;
            fifo_rdata <= 8'h00;
        end else if (bus.rd_en) begin
            if (fifo_q.size() != 0) fifo_rdata <= fifo_q.pop_front();
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        push_cnt++;
    endtask

    int total = 0;
    int bad   = 0;
    int exp_pkt = 0;
    int exp_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  hdr;
        int          n_pl;
        logic [63:0] pl;      // payload byte i at pl[8*i +: 8]
        logic [7:0]  par;
        logic [5:0]  exp_len;
        logic [1:0]  exp_addr;
        logic        exp_perr;
        logic        exp_aerr;
    } vec_t;

    vec_t vecs [6];

    // Feed one packet into an idle DUT and check it cycle by cycle; the
    // expected read pattern follows from hold and the packet length alone.
    task automatic run_pkt(input vec_t v, input int hold_at, input int hold_n, input string tag);
        int   issued   = 0;
        int   total_rd = v.n_pl + 2;
        int   prev_idx = -1;
        int   first_rd = -1;
        int   last_rd  = -1;
        int   done_at  = -1;
        int   got      = 0;
        logic finished = 1'b0;
        logic exp_rd, exp_bv, exp_done;

        push(v.hdr);
        for (int i = 0; i < v.n_pl; i++) push(v.pl[8*i +: 8]);
        push(v.par);

        for (int c = 0; c < 200; c++) begin
            bus.hold = (c >= hold_at) && (c < hold_at + hold_n);
            #1;
            exp_rd   = !bus.hold && (issued < total_rd);
            exp_bv   = (prev_idx >= 1) && (prev_idx <= v.n_pl);
            exp_done = (last_rd >= 0) && (c == last_rd + 2);

            check({tag, " rd_en"}, bus.rd_en, exp_rd);
            check({tag, " byte_valid"}, bus.byte_valid, exp_bv);
            if (exp_bv) check({tag, " byte_out"}, bus.byte_out, v.pl[8*(prev_idx-1) +: 8]);
            if (bus.byte_valid) got++;
            check({tag, " pkt_done"}, bus.pkt_done, exp_done);
            check({tag, " abort"}, bus.abort, 1'b0);
            if (exp_done) begin
                done_at = c;
                check({tag, " pkt_len"}, bus.pkt_len, v.exp_len);
                check({tag, " pkt_addr"}, bus.pkt_addr, v.exp_addr);
                check({tag, " parity_err"}, bus.parity_err, v.exp_perr);
                check({tag, " addr_err"}, bus.addr_err, v.exp_aerr);
            end

            if (exp_rd) begin
                if (first_rd < 0) first_rd = c;
                prev_idx = issued;
                issued++;
                if (issued == total_rd) last_rd = c;
            end else begin
                prev_idx = -1;
            end

            if ((last_rd >= 0) && (c == last_rd + 3)) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.hold = 1'b0;

        check({tag, " finished"}, finished, 1'b1);
        check({tag, " byte_count"}, got, v.n_pl);
        check({tag, " done_latency"}, done_at - first_rd, v.n_pl + 3 + hold_n);
        exp_pkt++;
        if (v.exp_perr || v.exp_aerr) exp_err++;
        check({tag, " pkt_count"}, bus.pkt_count, exp_pkt);
        check({tag, " err_count"}, bus.err_count, exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " byte_valid"}, bus.byte_valid, 1'b0);
        check({tag, " byte_out"}, bus.byte_out, 8'h00);
        check({tag, " pkt_len"}, bus.pkt_len, 6'd0);
        check({tag, " pkt_addr"}, bus.pkt_addr, 2'd0);
        check({tag, " pkt_done"}, bus.pkt_done, 1'b0);
        check({tag, " parity_err"}, bus.parity_err, 1'b0);
        check({tag, " addr_err"}, bus.addr_err, 1'b0);
        check({tag, " abort"}, bus.abort, 1'b0);
        check({tag, " pkt_count"}, bus.pkt_count, 16'd0);
        check({tag, " err_count"}, bus.err_count, 16'd0);
        check({tag, " rd_en"}, bus.rd_en, 1'b0);
    endtask

    initial begin
        int ab_at, n_ab, n_bv, n_done;

        vecs[0] = '{hdr: 8'h16, n_pl: 5, pl: 64'h0000_00EE_DDCC_BBAA, par: 8'hF8,
                    exp_len: 6'd5, exp_addr: 2'd2, exp_perr: 1'b0, exp_aerr: 1'b0};
        vecs[1] = '{hdr: 8'h16, n_pl: 5, pl: 64'h0000_00EE_DDCC_BBAA, par: 8'hF9,
                    exp_len: 6'd5, exp_addr: 2'd2, exp_perr: 1'b1, exp_aerr: 1'b0};
        vecs[2] = '{hdr: 8'h01, n_pl: 0, pl: 64'h0, par: 8'h01,
                    exp_len: 6'd0, exp_addr: 2'd1, exp_perr: 1'b0, exp_aerr: 1'b1};
        vecs[3] = '{hdr: 8'h0A, n_pl: 2, pl: 64'h0F55, par: 8'h50,
                    exp_len: 6'd2, exp_addr: 2'd2, exp_perr: 1'b0, exp_aerr: 1'b0};
        vecs[4] = '{hdr: 8'h07, n_pl: 1, pl: 64'h80, par: 8'h00,
                    exp_len: 6'd1, exp_addr: 2'd3, exp_perr: 1'b1, exp_aerr: 1'b1};
        vecs[5] = '{hdr: 8'h02, n_pl: 0, pl: 64'h0, par: 8'h02,
                    exp_len: 6'd0, exp_addr: 2'd2, exp_perr: 1'b0, exp_aerr: 1'b0};

        rst      = 1'b1;
        bus.hold = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Timeout: header + 2 of 5 payload bytes, then the FIFO runs dry.
        push(8'h16); push(8'h11); push(8'h22);
        ab_at = -1; n_ab = 0; n_bv = 0; n_done = 0;
        for (int c = 0; c < TIMEOUT + 10; c++) begin
            #1;
            if (bus.byte_valid) n_bv++;
            if (bus.pkt_done) n_done++;
            if (bus.abort) begin
                if (ab_at < 0) ab_at = c;
                n_ab++;
            end
            @(negedge clk);
        end
        check("timeout abort_cycle", ab_at, TIMEOUT + 4);
        check("timeout abort_pulses", n_ab, 1);
        check("timeout byte_count", n_bv, 2);
        check("timeout pkt_done_count", n_done, 0);
        exp_err = 1;
        check("timeout pkt_count", bus.pkt_count, exp_pkt);
        check("timeout err_count", bus.err_count, exp_err);

        // Table of packets, back to back from the post-abort IDLE state.
        for (int i = 0; i < 6; i++) begin
            run_pkt(vecs[i], 0, 0, $sformatf("vec%0d", i));
            @(negedge clk);
        end

        run_pkt(vecs[0], 3, 3, "hold");
        @(negedge clk);

        // Reset in the middle of the payload, then a clean packet.
        push(vecs[0].hdr);
        for (int i = 0; i < vecs[0].n_pl; i++) push(vecs[0].pl[8*i +: 8]);
        push(vecs[0].par);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_pkt = 0;
        exp_err = 0;
        @(negedge clk);
        run_pkt(vecs[0], 0, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "bench time limit expired");
    end

endmodule

// File: doc/router_port_rx.md
# router_port_rx

Synthesizable receive-side engine for one output port of the 1x3 router. It drains the port's output FIFO via `valid_out_N`/`rd_en_N` and re-frames the byte stream into packets. A packet is a header `{len[5:0], addr[1:0]}`, then `len` payload bytes, then one parity byte equal to the XOR of header and payload. The block checks parity and destination address, and reports per-packet status and running counters. It sits on each `data_out_N` port, and also serves as the self-checking receiver in router system benches.

## Interface
Parameters:
- `PORT_ID`, 2'd0: router output port this instance serves; expected header `addr`.
- `TIMEOUT`, 32: idle cycles mid-packet before abort. Range 2..255.
- `CNT_W`, 16: width of the packet and error counters.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `fifo_valid`, input, 1: router `valid_out_N`; the FIFO is non-empty.
- `fifo_data`, input, 8: router `data_out_N`; valid the cycle after `rd_en` is sampled high.
- `hold`, input, 1: downstream back-pressure; suppresses new reads.
- `rd_en`, output, 1: FIFO read strobe (combinational).
- `byte_out`, output, 8: payload byte.
- `byte_valid`, output, 1: one-cycle strobe per payload byte; header and parity bytes are never strobed.
- `pkt_len`, output, 6: length field of the current or last packet.
- `pkt_addr`, output, 2: address field of the current or last packet.
- `pkt_done`, output, 1: one-cycle pulse when the parity byte is consumed.
- `parity_err`, output, 1: valid with `pkt_done`; XOR mismatch.
- `addr_err`, output, 1: valid with `pkt_done`; `pkt_addr != PORT_ID`.
- `abort`, output, 1: one-cycle pulse; the packet was truncated by timeout.
- `pkt_count`, output, CNT_W: packets completed, including those with errors.
- `err_count`, output, CNT_W: packets that ended with `parity_err`, `addr_err` or `abort`.

## Operation
- States:
  - `IDLE`: wait for a header.
  - `HDR_WAIT`: header read issued.
  - `BODY`: payload and parity reads.
  - `DONE`: status cycle.
- Read issue: `rd_en = fifo_valid & ~hold & (req_left != 0)`.
  - `req_left` is loaded to 1 on entry to `IDLE`.
  - It is loaded to `len+1` when the header is captured.
  - It decrements on each `rd_en`.
  - This guarantees no read of an empty FIFO and no over-read into the next packet.
- Data strobe: `rd_q` is `rd_en` registered. Each cycle with `rd_q = 1` consumes `fifo_data`.
  - The first consumed byte is the header. It loads `pkt_len`, `pkt_addr` and the running parity, and moves the FSM to `BODY`.
  - The next `len` bytes drive `byte_out`/`byte_valid` and are XORed into the parity.
  - The final byte is compared with the parity accumulator.
- `rcv_left` counts bytes still to be consumed in `BODY`. When the parity byte is consumed, the FSM moves to `DONE`.
- `DONE`:
  - Pulses `pkt_done` with the error flags.
  - Increments `pkt_count`, and `err_count` if an error occurred.
  - Returns to `IDLE` (one bubble cycle between packets).
- `len = 0` is legal: header followed directly by parity. `byte_valid` never fires for that packet.
- Watchdog: in `HDR_WAIT`/`BODY`, a timer counts cycles with `rd_q = 0`; `rd_q = 1` clears it. `hold` does not pause the timer, so a long `hold` can cause an abort.
  - At `TIMEOUT`: pulse `abort`, increment `err_count` (not `pkt_count`), set `req_left = 1`, go to `IDLE`.
  - Any remaining stale bytes are then parsed as a header; this matches router soft-reset behaviour.
- Counters saturate at all-ones; they do not wrap.

## Timing
- Reset values: all outputs 0, FSM in `IDLE`, `req_left = 1`, timer 0, `rd_q = 0`.
  - `rd_en` may rise in the first cycle after reset if `fifo_valid` is high.
- Latency:
  - Header read (cycle 0) to header captured: 1 cycle.
  - First payload `rd_en`: cycle 1 at the earliest.
  - Each payload byte: `byte_valid` one cycle after its `rd_en`.
  - `pkt_done`: two cycles after the parity `rd_en`.
- Throughput: `len+3` cycles per packet when the FIFO holds the whole packet and `hold = 0`.
- `hold` asserted: `rd_en` drops in the same cycle. A byte already requested still arrives and is strobed next cycle.
- `fifo_valid` low mid-packet: no reads; the watchdog runs.
- Reset asserted mid-packet: everything clears immediately, and no `pkt_done`/`abort` is issued for the lost packet.

## Structure
- Shared package `router_pkg`: `HDR_LEN_MSB = 7`, `HDR_LEN_LSB = 2`, `HDR_ADDR_W = 2`, the FSM state enum, and a parity helper function.
- Sub-module `router_rx_watchdog`: the timeout counter with clear/enable and a `TIMEOUT` parameter.

## Test plan
- `PORT_ID = 2`. Stimulus: `16 AA BB CC DD EE` plus parity `0x16^0xAA^0xBB^0xCC^0xDD^0xEE`, FIFO preloaded, `hold = 0`. Required response:
  - 5 `byte_valid` pulses on consecutive cycles, bytes `AA..EE`;
  - `pkt_done` 8 cycles after the first `rd_en`;
  - `parity_err = 0`, `addr_err = 0`, `pkt_count = 1`.
- Same packet with the parity byte XOR `0x01` -> `parity_err = 1`, `err_count = 1`, `pkt_count = 1`.
- Header `0x01` (`len = 0`, `addr = 1`) with `PORT_ID = 2`, parity `0x01` -> no `byte_valid`; `pkt_done` with `addr_err = 1`.
- `hold` high for 3 cycles mid-payload -> `rd_en` low in exactly those cycles; no byte lost or duplicated.
- Header `0x16`, then 2 payload bytes, then `fifo_valid` low for 32 cycles -> `abort` pulse, `pkt_count = 0`, `err_count = 1`, FSM in `IDLE`.
- `rst` pulsed mid-payload -> all outputs 0 next edge; a following clean packet is received correctly.
